// File: rtl/ncl_sync_tx.sv
// ncl_sync_tx: clocked valid/ready word source driving a dual-rail NCL bus
// with the four-phase DATA/NULL protocol, paced by the consumer's ki.
module ncl_sync_tx #(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             ki,
  output logic [W-1:0]     rail_t,
  output logic [W-1:0]     rail_f,
  output logic [CNT_W-1:0] xfer_count,
  output logic             stall
);

  // Wide enough to hold TIMEOUT itself; a single bit when the timeout is disabled.
  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    SEND_DATA,
    SEND_NULL
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] ki_sync;
  logic                   ki_s;
  logic [WAIT_W-1:0]      wait_cnt;
  logic [WAIT_W-1:0]      wait_next;
  logic                   wait_hit;

  assign ki_s     = ki_sync[SYNC_STAGES-1];
  assign in_ready = (state == IDLE) && ki_s;

  // Bring the asynchronous completion signal into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ki_sync <= '0;
    end else begin
      ki_sync <= {ki_sync[SYNC_STAGES-2:0], ki};
    end
  end

  // Saturating next value of the phase wait counter and the cycle it reaches TIMEOUT.
  always_comb begin
    wait_next = wait_cnt;
    wait_hit  = 1'b0;
    if (wait_cnt != WAIT_MAX) begin
      wait_next = wait_cnt + WAIT_W'(1);
      wait_hit  = (TIMEOUT != 0) && (wait_next == WAIT_MAX);
    end
  end

  // Protocol sequencer: rails, transfer count, wait counter and sticky stall flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rail_t     <= '0;
      rail_f     <= '0;
      xfer_count <= '0;
      stall      <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (in_valid && in_ready) begin
            rail_t <= in_data;
            rail_f <= ~in_data;
            state  <= SEND_DATA;
          end
        end
        SEND_DATA: begin
          if (!ki_s) begin
            rail_t   <= '0;
            rail_f   <= '0;
            wait_cnt <= '0;
            state    <= SEND_NULL;
          end else begin
            wait_cnt <= wait_next;
            if (wait_hit) begin
              stall <= 1'b1;
            end
          end
        end
        SEND_NULL: begin
          if (ki_s) begin
            wait_cnt   <= '0;
            xfer_count <= xfer_count + CNT_W'(1);
            state      <= IDLE;
          end else begin
            wait_cnt <= wait_next;
            if (wait_hit) begin
              stall <= 1'b1;
            end
          end
        end
        default: begin
          rail_t   <= '0;
          rail_f   <= '0;
          wait_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
